// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state, requester and size encodings for bus_req_arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} arb_state_t;
  localparam int NUM_RQ = 3;
  localparam logic [1:0] RQ_DCACHE = 2'd0;
  localparam logic [1:0] RQ_UNCACHE = 2'd1;
  localparam logic [1:0] RQ_ICACHE = 2'd2;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  function automatic logic [1:0] rq_next(input logic [1:0] i);
    return i == 2'(NUM_RQ - 1) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/bus_req_arbiter_if.sv
// bus_req_arbiter_if: SRAM-like request channel between the arbiter and the AXI bridge.
interface bus_req_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req;
  logic wr;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [DATA_W-1:0] rdata;
  modport master(output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: combinational 3-way picker, searching upward from ptr with wrap.
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_RQ-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_RQ-1:0] gnt,
  output logic [1:0]        idx
);
  logic [1:0] c;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = ptr;
    for (int i = 0; i < NUM_RQ; i++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        gnt[c] = 1'b1;
        idx = c;
      end
      c = rq_next(c);
    end
  end
endmodule

// File: rtl/bus_req_arbiter.sv
// bus_req_arbiter: grants the bridge request channel to dcache/uncache/icache, one transaction at a time.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority dcache > uncache > icache.
module bus_req_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_RQ-1:0]          rq_valid,
  input  logic [NUM_RQ-1:0]          rq_wr,
  input  logic [2*NUM_RQ-1:0]        rq_size,
  input  logic [NUM_RQ*ADDR_W-1:0]   rq_addr,
  input  logic [NUM_RQ*DATA_W-1:0]   rq_wdata,
  output logic [NUM_RQ-1:0]          rq_done,
  output logic [DATA_W-1:0]          rq_rdata,
  output logic                       arb_busy,
  bus_req_arbiter_if.master          bus
);
  arb_state_t state;
  logic [NUM_RQ-1:0] owner_oh;
  logic [NUM_RQ-1:0] gnt;
  logic [1:0] idx;
  logic [1:0] ptr;
  bus_arb_pick u_pick (.req(rq_valid), .ptr(ptr), .gnt(gnt), .idx(idx));
`ifdef BUS_ARB_RR_EN
  // Pointer holds (last owner + 1) so the search starts just past the previous grant.
  always_ff @(posedge aclk)
    if (!aresetn) ptr <= RQ_DCACHE;
    else if (state == IDLE && |rq_valid) ptr <= rq_next(idx);
`else
  assign ptr = RQ_DCACHE;
`endif
  assign arb_busy = state != IDLE;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      owner_oh <= '0;
      rq_done <= '0;
      rq_rdata <= '0;
      bus.req <= 1'b0;
      bus.wr <= 1'b0;
      bus.size <= SZ_BYTE;
      bus.addr <= '0;
      bus.wdata <= '0;
    end else begin
      rq_done <= '0;
      case (state)
        IDLE: if (|rq_valid) begin
          state <= REQ;
          owner_oh <= gnt;
          bus.req <= 1'b1;
          bus.wr <= rq_wr[idx];
          bus.size <= rq_size[2*idx +: 2];
          bus.addr <= rq_addr[ADDR_W*idx +: ADDR_W];
          bus.wdata <= rq_wdata[DATA_W*idx +: DATA_W];
        end
        REQ: if (bus.addr_ok) begin
          bus.req <= 1'b0;
          state <= bus.data_ok ? DONE : WAIT;
          rq_done <= bus.data_ok ? owner_oh : '0;
          rq_rdata <= bus.data_ok ? bus.rdata : rq_rdata;
        end
        WAIT: if (bus.data_ok) begin
          state <= DONE;
          rq_done <= owner_oh;
          rq_rdata <= bus.rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_req_arbiter.md
# bus_req_arbiter

Shares the single SRAM-like request channel of the CPU-to-AXI bridge among three requesters: dcache refill/writeback engine, uncached data path, icache refill engine. It sits between the cache interfaces/uncache buffer and the bridge. It grants one requester at a time, latches its request, and drives the bridge handshake. It returns read data and a completion pulse to the owner. Exactly one transaction is outstanding at any time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- rq_valid  in  3  per-requester request; bit 0 dcache, 1 uncache, 2 icache; held until rq_done
- rq_wr  in  3  per-requester write flag
- rq_size  in  6  2 bits per requester; 0 byte, 1 half, 2 word
- rq_addr  in  3*ADDR_W  per-requester address
- rq_wdata  in  3*DATA_W  per-requester write data
- rq_done  out  3  one-cycle completion pulse to owner
- rq_rdata  out  DATA_W  read data, valid with rq_done
- arb_busy  out  1  transaction in progress (state != IDLE)
- bus_req  out  1  request to bridge
- bus_wr  out  1  write flag
- bus_size  out  2  size
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  bridge accepted address
- bus_data_ok  in  1  bridge returned data / write response
- bus_rdata  in  DATA_W  bridge read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if any rq_valid bit is set, the picker selects owner. Latch owner, wr, size, addr and wdata. Go to REQ. Otherwise stay in IDLE.
- REQ: bus_req=1, driven from the latched payload.
  - bus_addr_ok & !bus_data_ok -> WAIT.
  - bus_addr_ok & bus_data_ok -> DONE, and capture bus_rdata.
  - bus_data_ok without bus_addr_ok is ignored.
- WAIT: bus_req=0. On bus_data_ok, capture bus_rdata and go to DONE.
- DONE: rq_done[owner]=1 and rq_rdata=captured data. Go to IDLE.
- Requester deasserts rq_valid no later than the edge ending its rq_done cycle. An rq_valid seen in IDLE is always a new request.
- Changes on rq_* while not in IDLE are ignored, because the payload is latched.
- rq_rdata holds its last value outside DONE. For writes it is don't-care.
- Reset (at any state, including mid-transaction): FSM to IDLE. All outputs 0. Latches 0. RR pointer to 0. The bridge is reset with the same aresetn, so no in-flight cleanup is required.

## Timing
- rq_valid rising in cycle t (state IDLE) -> bus_req=1 in cycle t+1.
- addr_ok in cycle a -> bus_req=0 in a+1.
- data_ok in cycle d -> rq_done in d+1.
- Minimum transaction is 3 cycles, when addr_ok and data_ok arrive in the same cycle.
- Back-to-back: the next grant is decided in the IDLE cycle after DONE. This gives 1 idle bus cycle between transactions.
- All outputs are registered or decoded directly from state and latches. There is no combinational path from rq_* to bus_*.

## Configuration
- BUS_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (last_owner+1) mod 3.
  - The pointer updates on each grant.
  - A continuously requesting requester waits at most 2 transactions.
- Undefined: fixed priority, dcache(0) > uncache(1) > icache(2). There is no pointer register.

## Structure
- Package bus_arb_pkg holds:
  - state enum (IDLE/REQ/WAIT/DONE)
  - requester index constants RQ_DCACHE=0, RQ_UNCACHE=1, RQ_ICACHE=2
  - NUM_RQ=3
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
- One sub-module, bus_arb_pick: combinational 3-way picker. Inputs are the request vector and the start pointer. Outputs are a one-hot grant and an index. For fixed priority, the pointer input is tied to 0.

## Test plan
- Single dcache read:
  - Stimulus: rq_valid=3'b001, addr 0x1FC0_0100; bridge gives addr_ok 2 cycles after bus_req and data_ok 3 cycles later with 0xDEAD_BEEF.
  - Required: bus_addr=0x1FC0_0100, bus_wr=0, rq_done=3'b001 one cycle after data_ok, rq_rdata=0xDEAD_BEEF.
- Uncache byte write:
  - Stimulus: wr=1, size=0, addr 0xBFAF_F000, wdata 0x0000_00A5.
  - Required: bus_size=0, bus_wdata=0x0000_00A5, rq_done[1] after data_ok.
- Simultaneous rq_valid=3'b111, each requester re-requesting immediately:
  - Fixed priority: grant order 0,0,0…
  - BUS_ARB_RR_EN: grant order 0,1,2,0.
- addr_ok and data_ok in the same cycle: FSM goes REQ->DONE and rq_done fires 1 cycle later. Total 3 cycles from grant.
- Stray data_ok during REQ without addr_ok: ignored. bus_req stays 1 and no rq_done.
- aresetn low in WAIT: the next cycle has all outputs 0 and state IDLE. After release, a fresh rq_valid=3'b100 gets bus_req in the next cycle.
